// File: rtl/sel_bell_pkg.sv
// Shared definitions for the selection-bell machine: FSM state encoding,
// default sizing and the seconds-counter helper.
package sel_bell_pkg;

    localparam int SECS_W          = 6;
    localparam int DEF_N_PLAYERS   = 4;
    localparam int DEF_ANSWER_SECS = 30;
    localparam int DEF_TICK_DIV    = 50_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ANSWER  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Saturating one-second decrement; the countdown must never wrap below zero.
    function automatic logic [SECS_W-1:0] sat_dec(input logic [SECS_W-1:0] s);
        logic [SECS_W-1:0] r;
        if (s == {SECS_W{1'b0}}) begin
            r = s;
        end else begin
            r = s - SECS_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/buzz_arbiter_timer_sec_tick_gen.sv
// One-second prescaler: emits a single-cycle tick every TICK_DIV enabled cycles,
// and restarts from zero whenever en is low.
module sec_tick_gen
    import sel_bell_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    assign tick = en & (cnt_r == LAST);

    // Prescaler counter, held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (!en) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

endmodule

// File: rtl/buzz_arbiter_timer.sv
// Buzzer arbiter and answer timer: locks the first eligible press and counts down.
// Optional macro FOUL_DETECT_EN: presses in IDLE mark sticky fouls that disqualify a player.
module buzz_arbiter_timer
    import sel_bell_pkg::*;
#(
    parameter int N_PLAYERS   = DEF_N_PLAYERS,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int ANSWER_SECS = DEF_ANSWER_SECS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_PLAYERS-1:0] btn,
    output logic [N_PLAYERS-1:0] winner_onehot,
    output logic                 winner_valid,
    output logic [SECS_W-1:0]    secs_left,
    output logic                 finnal_flag,
    output logic [N_PLAYERS-1:0] foul
);

    localparam logic [SECS_W-1:0]    START_SECS = SECS_W'(ANSWER_SECS);
    localparam logic [SECS_W-1:0]    ONE_SEC    = SECS_W'(1);
    localparam logic [N_PLAYERS-1:0] ONE_N      = N_PLAYERS'(1);
    localparam logic [N_PLAYERS-1:0] ZERO_N     = {N_PLAYERS{1'b0}};

    state_t                 state_r, state_nxt;
    logic [N_PLAYERS-1:0]   btn_q_r;
    logic [N_PLAYERS-1:0]   press_s;
    logic [N_PLAYERS-1:0]   eligible_s;
    logic [N_PLAYERS-1:0]   pick_s;
    logic [N_PLAYERS-1:0]   foul_r;
    logic [N_PLAYERS-1:0]   winner_r, winner_nxt;
    logic                   valid_r, valid_nxt;
    logic [SECS_W-1:0]      secs_r, secs_nxt;
    logic                   flag_r, flag_nxt;
    logic                   tick_en_s;
    logic                   tick_s;

    assign press_s = btn & ~btn_q_r;

`ifdef FOUL_DETECT_EN
    // Sticky foul flags: any press while the round is not yet open disqualifies until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            foul_r <= ZERO_N;
        end else if (state_r == IDLE) begin
            foul_r <= foul_r | press_s;
        end else begin
            foul_r <= foul_r;
        end
    end
    assign eligible_s = press_s & ~foul_r;
`else
    assign foul_r     = ZERO_N;
    assign eligible_s = press_s;
`endif

    assign foul = foul_r;

    // Isolate the lowest set bit so the lowest index wins a simultaneous press.
    assign pick_s = eligible_s & (~eligible_s + ONE_N);

    // A restart must also clear the prescaler on the same edge it leaves ANSWER.
    assign tick_en_s = (state_r == ANSWER) & ~start;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en_s),
        .tick (tick_s)
    );

    // Next-state and next-output logic for the round FSM.
    always_comb begin
        state_nxt  = state_r;
        winner_nxt = winner_r;
        valid_nxt  = valid_r;
        secs_nxt   = secs_r;
        flag_nxt   = flag_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = ARMED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ARMED: begin
                if (pick_s != ZERO_N) begin
                    state_nxt  = ANSWER;
                    winner_nxt = pick_s;
                    valid_nxt  = 1'b1;
                    secs_nxt   = START_SECS;
                    flag_nxt   = 1'b1;
                end else begin
                    state_nxt = ARMED;
                end
            end
            ANSWER: begin
                if (start) begin
                    state_nxt  = ARMED;
                    winner_nxt = ZERO_N;
                    valid_nxt  = 1'b0;
                    secs_nxt   = {SECS_W{1'b0}};
                    flag_nxt   = 1'b1;
                end else if (tick_s) begin
                    if (secs_r == ONE_SEC) begin
                        state_nxt = EXPIRED;
                        secs_nxt  = {SECS_W{1'b0}};
                        flag_nxt  = 1'b0;
                    end else begin
                        secs_nxt = sat_dec(secs_r);
                    end
                end else begin
                    state_nxt = ANSWER;
                end
            end
            EXPIRED: begin
                if (start) begin
                    state_nxt  = ARMED;
                    winner_nxt = ZERO_N;
                    valid_nxt  = 1'b0;
                    secs_nxt   = {SECS_W{1'b0}};
                    flag_nxt   = 1'b1;
                end else begin
                    state_nxt = EXPIRED;
                end
            end
            default: begin
                state_nxt  = IDLE;
                winner_nxt = ZERO_N;
                valid_nxt  = 1'b0;
                secs_nxt   = {SECS_W{1'b0}};
                flag_nxt   = 1'b1;
            end
        endcase
    end

    // State, registered outputs and the button history used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            winner_r <= ZERO_N;
            valid_r  <= 1'b0;
            secs_r   <= {SECS_W{1'b0}};
            flag_r   <= 1'b1;
            btn_q_r  <= ZERO_N;
        end else begin
            state_r  <= state_nxt;
            winner_r <= winner_nxt;
            valid_r  <= valid_nxt;
            secs_r   <= secs_nxt;
            flag_r   <= flag_nxt;
            btn_q_r  <= btn;
        end
    end

    assign winner_onehot = winner_r;
    assign winner_valid  = valid_r;
    assign secs_left     = secs_r;
    assign finnal_flag   = flag_r;

endmodule

// File: tb/tb_buzz_arbiter_timer.sv
// Bench for buzz_arbiter_timer with a time-since-lock reference model.
module tb_buzz_arbiter_timer;

    localparam int NP = 4;
    localparam int TD = 4;
    localparam int AS = 3;
    localparam logic [15:0] RESET_VEC = 16'h0010;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NP-1:0] btn = 4'b0000;
    logic [NP-1:0] winner_onehot;
    logic          winner_valid;
    logic [5:0]    secs_left;
    logic          finnal_flag;
    logic [NP-1:0] foul;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: locked player index (-1 = none), round open, edges since lock.
    int          m_win     = -1;
    bit          m_open    = 1'b0;
    int          m_elapsed = 0;
    logic [3:0]  m_foul    = 4'b0000;
    logic [3:0]  m_prev    = 4'b0000;

    logic [15:0] got_v;
    logic [15:0] exp_v;

    buzz_arbiter_timer #(
        .N_PLAYERS   (NP),
        .TICK_DIV    (TD),
        .ANSWER_SECS (AS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .btn           (btn),
        .winner_onehot (winner_onehot),
        .winner_valid  (winner_valid),
        .secs_left     (secs_left),
        .finnal_flag   (finnal_flag),
        .foul          (foul)
    );

    always #5 clk = ~clk;

    assign got_v = {winner_onehot, winner_valid, secs_left, finnal_flag, foul};

    task automatic model_reset();
        m_win = -1; m_open = 1'b0; m_elapsed = 0; m_foul = 4'b0000; m_prev = 4'b0000;
    endtask

    task automatic model_step(input logic s, input logic [3:0] b);
        logic [3:0] pr;
        logic [3:0] el;
        pr = b & ~m_prev;
        if (m_win >= 0) begin
            if (s) begin
                m_win = -1; m_open = 1'b1;
            end else if (m_elapsed < 100000) begin
                m_elapsed++;
            end
        end else if (m_open) begin
            el = pr & ~m_foul;
            if (el != 4'b0000) begin
                for (int i = 3; i >= 0; i--) if (el[i]) m_win = i;
                m_elapsed = 0;
            end
        end else begin
            if (s) m_open = 1'b1;
`ifdef FOUL_DETECT_EN
            m_foul = m_foul | pr;
`endif
        end
        m_prev = b;
    endtask

    function automatic logic [15:0] exp_vec();
        logic [3:0] w;
        int q;
        int s;
        logic f;
        w = (m_win >= 0) ? (4'b0001 << m_win) : 4'b0000;
        q = m_elapsed / TD;
        s = (m_win < 0) ? 0 : ((q >= AS) ? 0 : AS - q);
        f = (m_win < 0) || (m_elapsed < AS * TD);
        return {w, (m_win >= 0), 6'(s), f, m_foul};
    endfunction

    // Apply inputs for one clock, advance the model at the edge, settle 1 time unit.
    task automatic step(input logic s, input logic [3:0] b);
        start = s;
        btn   = b;
        @(posedge clk);
        model_step(s, b);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (got_v !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_initial: got %h expected %h", got_v, RESET_VEC);
        end
        rst = 1'b0;
        model_reset();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        exp_v = exp_vec();
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++; $display("FAIL reset_prelock: got %h expected %h", got_v, exp_v);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (got_v !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", got_v, RESET_VEC);
        end
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if (got_v !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_held: got %h expected %h", got_v, RESET_VEC);
        end
        rst = 1'b0;
    endtask

    task automatic test_countdown();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        n_cmp++;
        if ({winner_onehot, winner_valid, secs_left} !== {4'b0100, 1'b1, 6'd3}) begin
            n_fail++; $display("FAIL countdown_lock: got %b/%b/%0d expected 0100/1/3",
                               winner_onehot, winner_valid, secs_left);
        end
        for (int k = 1; k <= 32; k++) begin
            step(1'b0, 4'b0000);
            exp_v = exp_vec();
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL countdown_cyc%0d: got %h expected %h", k, got_v, exp_v);
            end
            if (k == 4 || k == 8 || k == 12) begin
                n_cmp++;
                if (secs_left !== 6'(AS - k / TD)) begin
                    n_fail++; $display("FAIL countdown_secs%0d: got %0d expected %0d",
                                       k, secs_left, AS - k / TD);
                end
            end
            if (k >= 12) begin
                n_cmp++;
                if (finnal_flag !== 1'b0) begin
                    n_fail++; $display("FAIL countdown_flag%0d: got %b expected 0", k, finnal_flag);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0110);
        n_cmp++;
        if (winner_onehot !== 4'b0010) begin
            n_fail++; $display("FAIL simultaneous: got %b expected 0010", winner_onehot);
        end
        step(1'b1, 4'b0000);
        step(1'b1, 4'b1000);
        n_cmp++;
        if (winner_onehot !== 4'b1000 || winner_valid !== 1'b1) begin
            n_fail++; $display("FAIL armed_start_press: got %b/%b expected 1000/1",
                               winner_onehot, winner_valid);
        end
        step(1'b1, 4'b0100);
        exp_v = exp_vec();
        n_cmp++;
        if (got_v !== exp_v || winner_valid !== 1'b0) begin
            n_fail++; $display("FAIL answer_start_press: got %h expected %h", got_v, exp_v);
        end
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0001);
    endtask

    task automatic test_held_button();
        step(1'b0, 4'b0001);
        step(1'b1, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0001);
            n_cmp++;
            if (winner_valid !== 1'b0) begin
                n_fail++; $display("FAIL held_no_lock%0d: got %b expected 0", k, winner_valid);
            end
        end
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0001);
        n_cmp++;
        if (winner_onehot !== 4'b0001) begin
            n_fail++; $display("FAIL held_repress: got %b expected 0001", winner_onehot);
        end
    endtask

    task automatic test_restart();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        repeat (4) step(1'b0, 4'b0000);
        n_cmp++;
        if (secs_left !== 6'd2) begin
            n_fail++; $display("FAIL restart_pre: got %0d expected 2", secs_left);
        end
        step(1'b1, 4'b0000);
        n_cmp++;
        if ({winner_onehot, winner_valid, finnal_flag, secs_left} !== {4'b0000, 1'b0, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL restart_clear: got %b/%b/%b/%0d expected 0000/0/1/0",
                               winner_onehot, winner_valid, finnal_flag, secs_left);
        end
        step(1'b0, 4'b1000);
        n_cmp++;
        if (winner_onehot !== 4'b1000 || secs_left !== 6'd3) begin
            n_fail++; $display("FAIL restart_relock: got %b/%0d expected 1000/3",
                               winner_onehot, secs_left);
        end
    endtask

`ifdef FOUL_DETECT_EN
    task automatic test_foul();
        rst = 1'b1;
        btn = 4'b0000;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 4'b0001);
        n_cmp++;
        if (foul !== 4'b0001) begin
            n_fail++; $display("FAIL foul_set: got %b expected 0001", foul);
        end
        step(1'b0, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0011);
        n_cmp++;
        if (winner_onehot !== 4'b0010) begin
            n_fail++; $display("FAIL foul_mask: got %b expected 0010", winner_onehot);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] b;
        logic       s;
        b = btn;
        for (int k = 0; k < 1500; k++) begin
            s = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) b = 4'($urandom_range(0, 15));
            step(s, b);
            exp_v = exp_vec();
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", k, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_simultaneous();
        test_held_button();
        test_restart();
`ifdef FOUL_DETECT_EN
        test_foul();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
